// File: rtl/eth_pcs_rx_descrambler.sv
// ---------------------------------------------------------------------------
// eth_pcs_rx_descrambler
//
// 10GBASE-R PCS receive descrambler and 66b block assembler.  Sits behind the
// RX gearbox, self-synchronously descrambles the payload with 1 + x^39 + x^58
// and hands complete 66b blocks (2b header + 64b payload) to the 64b/66b
// decoder with a one-cycle valid strobe, gated by block lock.
//
// Optional feature macro: ETH_PCS_RX_DESCR_BYPASS_EN
//   defined   : adds input i_bypass; when high, the payload passes through
//               unmodified while the scrambler history keeps tracking the
//               line, so the path can be switched mid-stream without resync.
//   undefined : no bypass port, payload is always descrambled.
//
// The file also carries eth_pcs_rx_descrambler_chk, a property checker meant
// to be bound or instantiated alongside the block in simulation.
// ---------------------------------------------------------------------------

module eth_pcs_rx_descrambler #(
    parameter int W_DATA      = 32,
    parameter int W_SYNC      = 2,
    parameter int DESCR_ORDER = 58
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_grbx_data_valid,
    input  logic              i_grbx_hdr_valid,
    input  logic [W_SYNC-1:0] i_grbx_hdr,
    input  logic [W_DATA-1:0] i_grbx_data,
    input  logic              i_blk_lock,
`ifdef ETH_PCS_RX_DESCR_BYPASS_EN
    input  logic              i_bypass,
`endif
    output logic              o_blk_valid,
    output logic [W_SYNC-1:0] o_blk_hdr,
    output logic [63:0]       o_blk_data,
    output logic              o_seq_err
);

    // Gearbox words that make up one 64-bit payload (1 or 2).
    localparam int WORDS_PER_BLK = 64 / W_DATA;
    localparam bit SINGLE_WORD   = (WORDS_PER_BLK == 1);
    // Near tap of the polynomial; the far tap equals DESCR_ORDER.
    localparam int TAP_NEAR      = 39;
    // History plus the current word, oldest bit at index 0.
    localparam int EXT_W         = DESCR_ORDER + W_DATA;
    localparam int NEAR_OFFSET   = DESCR_ORDER - TAP_NEAR;

    typedef enum logic [0:0] {
        WAIT_FIRST  = 1'b0,
        WAIT_SECOND = 1'b1
    } state_t;

    // Descramble one word.  ext holds {current word, last DESCR_ORDER received
    // bits}, so the current bit j sits at ext[DESCR_ORDER+j], the bit received
    // 39 positions earlier at ext[j+NEAR_OFFSET] and the one 58 positions
    // earlier at ext[j].  Taps that land inside the current word (only
    // possible for 64-bit words) are picked up naturally from the upper part.
    function automatic logic [W_DATA-1:0] descramble(input logic [EXT_W-1:0] ext);
        logic [W_DATA-1:0] res;
        res = {W_DATA{1'b0}};
        for (int j = 0; j < W_DATA; j++) begin
            res[j] = ext[DESCR_ORDER + j] ^ ext[j + NEAR_OFFSET] ^ ext[j];
        end
        return res;
    endfunction

    state_t                 state_r;
    logic [DESCR_ORDER-1:0] scr_state_r;
    logic [W_DATA-1:0]      blk_buf_r;
    logic [W_SYNC-1:0]      hdr_r;

    logic                   bypass_s;
    logic [EXT_W-1:0]       ext_s;
    logic [DESCR_ORDER-1:0] scr_next_s;
    logic [W_DATA-1:0]      word_out_s;
    logic [63:0]            assembled_s;

`ifdef ETH_PCS_RX_DESCR_BYPASS_EN
    assign bypass_s = i_bypass;
`else
    assign bypass_s = 1'b0;
`endif

    // Scrambled history extended with the incoming word; the next history is
    // simply the newest DESCR_ORDER bits of that vector.
    always_comb begin
        ext_s      = {i_grbx_data, scr_state_r};
        scr_next_s = ext_s[EXT_W-1 -: DESCR_ORDER];
    end

    // Payload word after descrambling, or raw when bypassed.
    always_comb begin
        word_out_s = {W_DATA{1'b0}};
        if (bypass_s) begin
            word_out_s = i_grbx_data;
        end else begin
            word_out_s = descramble(ext_s);
        end
    end

    // Full 64-bit payload as it would look if the current word ends the block.
    generate
        if (WORDS_PER_BLK == 2) begin : g_two_words
            assign assembled_s = {word_out_s, blk_buf_r};
        end else begin : g_one_word
            assign assembled_s = word_out_s;
        end
    endgenerate

    // Scrambler history: tracks every accepted word regardless of lock or
    // framing, which is what makes the descrambler self-synchronising.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            scr_state_r <= {DESCR_ORDER{1'b0}};
        end else if (i_grbx_data_valid) begin
            scr_state_r <= scr_next_s;
        end else begin
            scr_state_r <= scr_state_r;
        end
    end

    // Block framing FSM with registered block / error outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r     <= WAIT_FIRST;
            blk_buf_r   <= {W_DATA{1'b0}};
            hdr_r       <= {W_SYNC{1'b0}};
            o_blk_valid <= 1'b0;
            o_blk_hdr   <= {W_SYNC{1'b0}};
            o_blk_data  <= 64'h0;
            o_seq_err   <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            o_blk_valid <= 1'b0;
            o_seq_err   <= 1'b0;
            if (i_grbx_data_valid) begin
                case (state_r)
                    WAIT_FIRST: begin
                        if (!i_grbx_hdr_valid) begin
                            // Payload word with no block start: drop it.
                            o_seq_err <= 1'b1;
                        end else if (SINGLE_WORD) begin
                            o_blk_valid <= i_blk_lock;
                            o_blk_hdr   <= i_grbx_hdr;
                            o_blk_data  <= assembled_s;
                        end else begin
                            blk_buf_r <= word_out_s;
                            hdr_r     <= i_grbx_hdr;
                            state_r   <= WAIT_SECOND;
                        end
                    end
                    WAIT_SECOND: begin
                        if (i_grbx_hdr_valid) begin
                            // New block started early: lose the partial one
                            // and restart assembly with this word.
                            o_seq_err <= 1'b1;
                            blk_buf_r <= word_out_s;
                            hdr_r     <= i_grbx_hdr;
                        end else begin
                            o_blk_valid <= i_blk_lock;
                            o_blk_hdr   <= hdr_r;
                            o_blk_data  <= assembled_s;
                            state_r     <= WAIT_FIRST;
                        end
                    end
                    default: begin
                        state_r <= WAIT_FIRST;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// ---------------------------------------------------------------------------
// eth_pcs_rx_descrambler_chk
//
// Output-protocol properties of eth_pcs_rx_descrambler: a word either
// completes a block or raises a sequence error, never both, and both strobes
// are quiet in the cycle after reset.
// ---------------------------------------------------------------------------

module eth_pcs_rx_descrambler_chk (
    input logic i_clk,
    input logic i_reset,
    input logic o_blk_valid,
    input logic o_seq_err
);

    // Block strobe and sequence error are mutually exclusive.
    always @(posedge i_clk) begin
        if (!i_reset) begin
            a_excl: assert (!(o_blk_valid && o_seq_err))
                else $error("blk_valid and seq_err asserted together");
        end
    end

    // Strobes must be low right after a reset cycle.
    a_reset_quiet: assert property (@(posedge i_clk)
        $past(i_reset) |-> (!o_blk_valid && !o_seq_err))
        else $error("strobe active after reset");

endmodule

// File: doc/eth_pcs_rx_descrambler.md
Name: eth_pcs_rx_descrambler

Overview:
Sits directly downstream of the RX gearbox in the 10GBASE-R PCS receive path. Accepts aligned W_DATA-bit payload words and 2-bit sync headers, and self-synchronously descrambles the payload (polynomial 1 + x^39 + x^58). It assembles each 66b block (2b header + 64b payload) and presents it to the 64b/66b decoder with a one-cycle valid strobe, gated by block lock.

Parameters:
W_DATA, 32, gearbox word width; legal values 32 or 64; WORDS_PER_BLK = 64/W_DATA
W_SYNC, 2, sync header width
DESCR_ORDER, 58, scrambler state length; fixed, not overridable in practice

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_grbx_data_valid  in  1  payload word valid this cycle; low on gearbox idle (skip) cycles
i_grbx_hdr_valid  in  1  marks first word of a block; ignored unless i_grbx_data_valid=1
i_grbx_hdr  in  W_SYNC  sync header; sampled only with i_grbx_hdr_valid & i_grbx_data_valid
i_grbx_data  in  W_DATA  scrambled payload word, bit 0 first on the wire
i_blk_lock  in  1  block lock from block sync
o_blk_valid  out  1  one-cycle strobe, block outputs valid
o_blk_hdr  out  W_SYNC  header of the assembled block
o_blk_data  out  64  descrambled payload; word 0 in [W_DATA-1:0]
o_seq_err  out  1  one-cycle pulse on a framing sequence error

Behaviour:
- Reset: o_blk_valid=0, o_blk_hdr=0, o_blk_data=0, o_seq_err=0. Scrambler state=0. FSM=WAIT_FIRST. Partial block discarded.
- Descramble for global block bit i: out[i] = in[i] ^ x[i-39] ^ x[i-58], where x is the received (scrambled) bit stream.
- With W_DATA<=39, every tap falls in the 58-bit state register. Descramble is combinational per word from state.
- State update: on every accepted word (i_grbx_data_valid=1), shift in the scrambled input bits, so state holds the last 58 received bits. Updates regardless of lock or FSM state; this gives self-synchronisation.
- On i_grbx_data_valid=0: no state change, no FSM change.
- FSM, W_DATA=32:
  - WAIT_FIRST: a valid word with hdr_valid stores the descrambled word into low half and latches the header, then goes to WAIT_SECOND. A valid word without hdr_valid is dropped, pulses o_seq_err, and stays in WAIT_FIRST.
  - WAIT_SECOND: a valid word without hdr_valid completes the block. The cycle after, o_blk_valid=i_blk_lock (sampled when the word is accepted), and o_blk_data/o_blk_hdr are updated. FSM returns to WAIT_FIRST.
  - WAIT_SECOND, valid word with hdr_valid: the partial block is dropped and o_seq_err pulses. The new word is taken as word 0 and the FSM stays in WAIT_SECOND.
- W_DATA=64: every valid word must carry hdr_valid, or o_seq_err pulses and the word is dropped. A block is output the next cycle; the FSM stays in WAIT_FIRST.
- Latency: o_blk_valid is asserted exactly 1 cycle after the last word of the block is accepted.
- o_blk_data and o_blk_hdr hold their value between strobes.
- When i_blk_lock=0: no o_blk_valid. Assembly, state update and o_seq_err continue normally.
- Reset asserted mid-block: partial block lost; no strobe is produced for it.

Optional Feature:
ETH_PCS_RX_DESCR_BYPASS_EN:
- Defined: adds input port i_bypass (1 bit). When high, out[i]=in[i] and scrambler state still updates, so the path can switch mid-stream without resync. i_bypass is sampled per word.
- Undefined: no port; always descramble.

Test Plan:
- Reset, then W_DATA=32 with lock=1. Send word0=0xFFFFFFFF, hdr=2'b01, hdr_valid=1; then word1=0x00000000.
  -> o_blk_valid for 1 cycle after word1, o_blk_hdr=2'b01, o_blk_data=0x03FFFF80_FFFFFFFF.
- Same two words with one data_valid=0 gap between them.
  -> identical output, strobe 1 cycle after word1; state unchanged across the gap.
- Stream of 20 blocks of scrambled all-zero payload after 58 bits of arbitrary prefix.
  -> every output block from block 2 onward has o_blk_data=0 (self-sync).
- In WAIT_SECOND, send hdr_valid=1 again.
  -> o_seq_err=1 for 1 cycle, no strobe, next block is assembled correctly.
- In WAIT_FIRST, send a valid word with hdr_valid=0.
  -> o_seq_err pulse, word dropped.
- i_blk_lock=0 during a complete block.
  -> no o_blk_valid.
- Assert i_reset between word0 and word1.
  -> no strobe, all outputs 0, first block after reset output correctly.
